pixel_addr_pipe: RTL and testbench

PIXEL_ADDR_PIPE -- requirements
Module: pixel_addr_pipe

---
 rtl/pixel_addr_pipe_if.sv | 32 +++
 rtl/pixel_addr_pipe.sv | 175 +++++++++++++++++
 tb/tb_pixel_addr_pipe.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_addr_pipe_if.sv
// Pixel request / packed-address response bus for pixel_addr_pipe.
// master = producer of pixels and consumer of addresses; slave = the pipe.
interface pixel_addr_pipe_if #(
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = 17,
  parameter int OFF_W   = 3
);
  // Both sides: a beat moves on a rising clk edge where rts and rtr are both
  // high. The sender keeps its payload and rts steady until that edge. rtr
  // may depend on state only, never combinationally on rts.
  logic [9:0]         in_x;
  logic [9:0]         in_y;
  logic [COLOR_W-1:0] in_color;
  logic               in_rts;
  logic               in_rtr;
  logic [ADDR_W-1:0]  out_addr;
  logic [OFF_W-1:0]   out_offset;
  logic [COLOR_W-1:0] out_color;
  logic               out_rts;
  logic               out_rtr;
  logic [7:0]         drop_cnt;

  modport master (
    output in_x, in_y, in_color, in_rts, out_rtr,
    input  in_rtr, out_addr, out_offset, out_color, out_rts, drop_cnt
  );

  modport slave (
    input  in_x, in_y, in_color, in_rts, out_rtr,
    output in_rtr, out_addr, out_offset, out_color, out_rts, drop_cnt
  );
endinterface

// File: rtl/pixel_addr_pipe.sv
// Pixel (x,y) -> packed framebuffer word address: input FIFO, then S1 linear index, S2 group address.
// Define PIX_ADDR_CLIP_EN to drop out-of-frame requests and count them on drop_cnt.
module pixel_addr_pipe #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int PIX_PER_GRP   = 8,
  parameter int WORDS_PER_GRP = 3,
  parameter int COLOR_W       = 12,
  parameter int ADDR_W        = 17,
  parameter int FIFO_DEPTH    = 4
) (
  input logic clk,
  input logic rst_,
  pixel_addr_pipe_if.slave bus
);
  localparam int OFF_W = $clog2(PIX_PER_GRP);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LIN_W = 20;

  localparam logic [LIN_W-1:0] H_RES_L = LIN_W'(H_RES);
  localparam logic [31:0]      WPG_U   = 32'(WORDS_PER_GRP);
  localparam logic [PTR_W:0]   PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  if (PIX_PER_GRP < 2 || (PIX_PER_GRP & (PIX_PER_GRP - 1)) != 0) begin : g_chk_ppg
    $error("PIX_PER_GRP must be a power of 2 and at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (H_RES < 1 || V_RES < 1) begin : g_chk_res
    $error("H_RES and V_RES must be positive");
  end

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [9:0]         fifo_x_q [FIFO_DEPTH];
  logic [9:0]         fifo_y_q [FIFO_DEPTH];
  logic [COLOR_W-1:0] fifo_c_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic               rdy_q, rdy_d;

  logic               s1_valid_q, s1_valid_d;
  logic [LIN_W-1:0]   s1_lin_q, s1_lin_d;
  logic [COLOR_W-1:0] s1_color_q, s1_color_d;

  logic               s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0]  s2_addr_q, s2_addr_d;
  logic [OFF_W-1:0]   s2_offset_q, s2_offset_d;
  logic [COLOR_W-1:0] s2_color_q, s2_color_d;

  logic               full, empty, push, pop, in_rtr;
  logic               s1_adv, s2_adv, oob;
  logic [9:0]         head_x, head_y;
  logic [COLOR_W-1:0] head_c;
  logic [LIN_W-1:0]   head_lin, s1_grp;

`ifdef PIX_ADDR_CLIP_EN
  localparam logic [31:0] H_RES_U = 32'(H_RES);
  localparam logic [31:0] V_RES_U = 32'(V_RES);
  logic [7:0] drop_cnt_q, drop_cnt_d;
`endif

  assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  // rdy_q keeps in_rtr low through reset and until the first edge after it
  assign in_rtr = rdy_q && !full;
  assign push   = bus.in_rts && in_rtr;
  assign s2_adv = !s2_valid_q || bus.out_rtr;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign pop    = !empty && s1_adv;

  assign head_x   = fifo_x_q[rd_ptr_q[PTR_W-1:0]];
  assign head_y   = fifo_y_q[rd_ptr_q[PTR_W-1:0]];
  assign head_c   = fifo_c_q[rd_ptr_q[PTR_W-1:0]];
  assign head_lin = {10'd0, head_y} * H_RES_L + {10'd0, head_x};
  assign s1_grp   = s1_lin_q >> OFF_W;

`ifdef PIX_ADDR_CLIP_EN
  assign oob = ({22'd0, head_x} >= H_RES_U) || ({22'd0, head_y} >= V_RES_U);
`else
  assign oob = 1'b0;
`endif

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rdy_d       = 1'b1;
    s1_valid_d  = s1_valid_q;
    s1_lin_d    = s1_lin_q;
    s1_color_d  = s1_color_q;
    s2_valid_d  = s2_valid_q;
    s2_addr_d   = s2_addr_q;
    s2_offset_d = s2_offset_q;
    s2_color_d  = s2_color_q;
`ifdef PIX_ADDR_CLIP_EN
    drop_cnt_d  = drop_cnt_q;
`endif

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    // An out-of-frame head is popped but never occupies S1
    if (s1_adv) begin
      s1_valid_d = pop && !oob;
      if (pop) begin
        s1_lin_d   = head_lin;
        s1_color_d = head_c;
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_d   = ADDR_W'(32'(s1_grp) * WPG_U);
        s2_offset_d = s1_lin_q[OFF_W-1:0];
        s2_color_d  = s1_color_q;
      end
    end

`ifdef PIX_ADDR_CLIP_EN
    if (pop && oob && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_x_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_x;
      fifo_y_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_y;
      fifo_c_q[wr_ptr_q[PTR_W-1:0]] <= bus.in_color;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rdy_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_lin_q    <= '0;
      s1_color_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_addr_q   <= '0;
      s2_offset_q <= '0;
      s2_color_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rdy_q       <= rdy_d;
      s1_valid_q  <= s1_valid_d;
      s1_lin_q    <= s1_lin_d;
      s1_color_q  <= s1_color_d;
      s2_valid_q  <= s2_valid_d;
      s2_addr_q   <= s2_addr_d;
      s2_offset_q <= s2_offset_d;
      s2_color_q  <= s2_color_d;
    end
  end

`ifdef PIX_ADDR_CLIP_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) drop_cnt_q <= 8'd0;
    else       drop_cnt_q <= drop_cnt_d;
  end
  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = 8'd0;
`endif

  assign bus.in_rtr     = in_rtr;
  assign bus.out_rts    = s2_valid_q;
  assign bus.out_addr   = s2_addr_q;
  assign bus.out_offset = s2_offset_q;
  assign bus.out_color  = s2_color_q;
endmodule

// File: tb/tb_pixel_addr_pipe.sv
// Bench for pixel_addr_pipe: directed cases plus randomized traffic against an arithmetic model.
module tb_pixel_addr_pipe;
  localparam int H_RES = 640, V_RES = 480, PPG = 8, WPG = 3;
  localparam int COLOR_W = 12, ADDR_W = 17, OFF_W = 3, FIFO_DEPTH = 4;
  localparam int W = ADDR_W + OFF_W + COLOR_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  pixel_addr_pipe_if #(.COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .OFF_W(OFF_W)) bus();

  pixel_addr_pipe #(
    .H_RES(H_RES), .V_RES(V_RES), .PIX_PER_GRP(PPG), .WORDS_PER_GRP(WPG),
    .COLOR_W(COLOR_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard
  logic [W-1:0]       exp_q[$];
  int                 exp_drop = 0;
  int                 n_out = 0;
  logic [ADDR_W-1:0]  got_addr[$];
  logic [OFF_W-1:0]   got_off[$];
  logic [COLOR_W-1:0] got_color[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int x, input int y, input int c);
    int lin, addr, off;
    lin  = y * H_RES + x;
    addr = ((lin / PPG) * WPG) % (1 << ADDR_W);
    off  = lin % PPG;
    return {ADDR_W'(addr), OFF_W'(off), COLOR_W'(c)};
  endfunction

  function automatic bit out_of_frame(input int x, input int y);
    return (x >= H_RES) || (y >= V_RES);
  endfunction

  // compare process: evaluates every cycle at the falling edge
  logic         prev_hold = 1'b0;
  logic [W-1:0] prev_data, cur, exp_v;
  always @(negedge clk) begin
    cur = {bus.out_addr, bus.out_offset, bus.out_color};
    if (!rst_) begin
      exp_q.delete();
      exp_drop  = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("stall_rts_stable", bus.out_rts, 1);
        chk("stall_data_stable", cur, prev_data);
      end
      if (bus.out_rts && bus.out_rtr) begin
        if (exp_q.size() == 0) chk("unexpected_output", bus.out_rts, 0);
        else begin
          exp_v = exp_q.pop_front();
          chk("out_data", cur, exp_v);
        end
        n_out++;
        got_addr.push_back(bus.out_addr);
        got_off.push_back(bus.out_offset);
        got_color.push_back(bus.out_color);
      end
      if (bus.in_rts && bus.in_rtr) begin
`ifdef PIX_ADDR_CLIP_EN
        if (out_of_frame(int'(bus.in_x), int'(bus.in_y)))
          exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
        else
          exp_q.push_back(model(int'(bus.in_x), int'(bus.in_y), int'(bus.in_color)));
`else
        exp_q.push_back(model(int'(bus.in_x), int'(bus.in_y), int'(bus.in_color)));
`endif
      end
      prev_hold = bus.out_rts && !bus.out_rtr;
      prev_data = cur;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y, input int c);
    bit ok;
    int n;
    n = 0;
    bus.in_x = 10'(x); bus.in_y = 10'(y); bus.in_color = COLOR_W'(c);
    bus.in_rts = 1'b1;
    do begin
      @(negedge clk);
      ok = bus.in_rtr;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", ok, 1);
    bus.in_rts = 1'b0;
  endtask

  task automatic wait_outs(input int target, input int budget);
    int n;
    n = 0;
    while (n_out < target && n < budget) begin
      tick();
      n++;
    end
    chk("wait_outputs", n_out >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int rec, acc, idx, hi6, hi10, thr, n;
    bus.in_rts = 1'b0; bus.out_rtr = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_color = '0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rtr", bus.in_rtr, 0);
    chk("rst_out_rts", bus.out_rts, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_offset", bus.out_offset, 0);
    chk("rst_out_color", bus.out_color, 0);
    tick();
    rst_ = 1'b1;
    @(negedge clk);
    chk("rtr_before_first_edge", bus.in_rtr, 0);
    @(negedge clk);
    chk("rtr_after_first_edge", bus.in_rtr, 1);
    tick();

    // first pixel and its latency
    bus.out_rtr = 1'b1;
    send(0, 0, 'hABC);
    @(negedge clk); chk("lat_k", bus.out_rts, 0);
    @(negedge clk); chk("lat_k1", bus.out_rts, 0);
    @(negedge clk);
    chk("lat_k2_rts", bus.out_rts, 1);
    chk("lat_k2_addr", bus.out_addr, 0);
    chk("lat_k2_offset", bus.out_offset, 0);
    chk("lat_k2_color", bus.out_color, 'hABC);
    tick();

    // address arithmetic corner points
    rec = n_out;
    send(9, 1, 'h123);
    send(639, 479, 'h456);
    wait_outs(rec + 2, 20);
    chk("addr_9_1", got_addr[rec], 243);
    chk("off_9_1", got_off[rec], 1);
    chk("addr_639_479", got_addr[rec+1], 115197);
    chk("off_639_479", got_off[rec+1], 7);
    chk("color_639_479", got_color[rec+1], 'h456);

    // full backpressure: capacity is FIFO + two stages
    repeat (3) tick();
    bus.out_rtr = 1'b0;
    acc = 0; idx = 0;
    bus.in_x = 10'(idx * 3); bus.in_y = 10'(idx); bus.in_color = COLOR_W'(idx);
    bus.in_rts = 1'b1;
    repeat (12) begin
      @(negedge clk);
      n = (bus.in_rts && bus.in_rtr) ? 1 : 0;
      acc += n;
      tick();
      if (n == 1) begin
        idx++;
        if (idx < 8) begin
          bus.in_x = 10'(idx * 3); bus.in_y = 10'(idx); bus.in_color = COLOR_W'(idx);
        end else bus.in_rts = 1'b0;
      end
    end
    chk("stall_accepted", acc, 6);
    @(negedge clk);
    chk("stall_in_rtr_low", bus.in_rtr, 0);
    tick();
    bus.in_rts = 1'b0;
    bus.out_rtr = 1'b1;
    hi6 = 0; hi10 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_rts) begin
        hi10++;
        if (i < 6) hi6++;
      end
    end
    chk("release_back_to_back", hi6, 6);
    chk("release_total", hi10, 6);
    tick();

    // out-of-frame requests
    rec = n_out;
    send(640, 0, 1);
    send(0, 480, 2);
    send(1, 0, 3);
`ifdef PIX_ADDR_CLIP_EN
    wait_outs(rec + 1, 20);
    repeat (4) tick();
    chk("clip_out_count", n_out - rec, 1);
    chk("clip_addr", got_addr[rec], 0);
    chk("clip_off", got_off[rec], 1);
    chk("clip_drop_cnt", bus.drop_cnt, 2);
`else
    wait_outs(rec + 3, 20);
    chk("noclip_addr", got_addr[rec], 240);
    chk("noclip_off", got_off[rec], 0);
    chk("noclip_drop_cnt", bus.drop_cnt, 0);
`endif

    // reset with work in flight
    repeat (3) tick();
    bus.out_rtr = 1'b0;
    send(5, 5, 'h111);
    send(6, 6, 'h222);
    send(7, 7, 'h333);
    rst_ = 1'b0;
    #1;
    chk("midrst_out_rts", bus.out_rts, 0);
    chk("midrst_in_rtr", bus.in_rtr, 0);
    repeat (2) tick();
    rst_ = 1'b1;
    rec = n_out;
    bus.out_rtr = 1'b1;
    repeat (10) tick();
    chk("no_stale_after_reset", n_out - rec, 0);
    chk("post_rst_drop_cnt", bus.drop_cnt, 0);
    chk("post_rst_in_rtr", bus.in_rtr, 1);

    // randomized traffic with varying backpressure
    thr = 7;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) thr = $urandom_range(1, 10);
      bus.in_rts   = ($urandom_range(0, 3) != 0);
      bus.in_x     = 10'($urandom_range(0, 900));
      bus.in_y     = 10'($urandom_range(0, 520));
      bus.in_color = COLOR_W'($urandom);
      bus.out_rtr  = ($urandom_range(0, 9) < thr);
      tick();
    end
    bus.in_rts = 1'b0;
    bus.out_rtr = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_out_rts", bus.out_rts, 0);
    chk("final_drop_cnt", bus.drop_cnt, exp_drop);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
